// File: rtl/bnn_seq_controller.sv
// Top-level BNN sequencer: gathers serial conv bits into a feature map, streams it
// to the FC engine once per class with backpressure, and reports the argmax class.
module bnn_seq_controller #(
  parameter int CONV_N    = 3,
  parameter int FC_LANES  = 12,
  parameter int FMAP_BITS = 2028,
  parameter int CLASSES   = 10,
  parameter int SCORE_W   = 12,
  localparam int CLS_W    = (CLASSES > 1) ? $clog2(CLASSES) : 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  output logic [CONV_N-1:0]         conv_start,
  input  logic [CONV_N-1:0]         conv_result,
  input  logic [CONV_N-1:0]         conv_result_valid,
  output logic [FC_LANES-1:0]       fc_din,
  output logic                      fc_valid,
  input  logic                      fc_ready,
  output logic                      fc_last,
  output logic [CLS_W-1:0]          fc_class,
  input  logic signed [SCORE_W-1:0] fc_result,
  input  logic                      fc_result_valid,
  output logic [CLASSES-1:0]        classes,
  output logic                      ovalid,
  output logic                      busy,
  output logic                      overflow
);

  localparam int REG    = FMAP_BITS / CONV_N;
  localparam int BEATS  = FMAP_BITS / FC_LANES;
  localparam int PTR_W  = $clog2(REG + 1);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FM_W   = (FMAP_BITS > 1) ? $clog2(FMAP_BITS) : 1;

  // Handshake: a beat transfers on any rising clk edge where fc_valid && fc_ready;
  // while fc_ready is low, fc_din/fc_last/fc_class hold their values.
  typedef enum logic [2:0] {S_IDLE, S_CONV, S_STREAM, S_WAIT_RES, S_DONE} state_t;
  state_t state, state_nx;

  logic [FMAP_BITS-1:0]      fmap;
  logic [PTR_W-1:0]          ptr [CONV_N];
  logic [BEAT_W-1:0]         beat;
  logic [CLS_W-1:0]          cls_idx;
  logic signed [SCORE_W-1:0] best_score;
  logic [CLS_W-1:0]          best_idx;

  logic                      all_full;
  logic                      fire;
  logic                      last_beat;
  logic                      last_class;
  logic                      res_better;
  logic [CLS_W-1:0]          win_idx;
  logic [FM_W-1:0]           wr_idx [CONV_N];
  logic [CONV_N-1:0]         wr_en;
  logic [FM_W-1:0]           rd_base;

  always_comb begin
    all_full = 1'b1;
    for (int c = 0; c < CONV_N; c++) begin
      wr_idx[c] = FM_W'(c * REG) + FM_W'(ptr[c]);
      wr_en[c]  = (state == S_CONV) && conv_result_valid[c] && (ptr[c] != PTR_W'(REG));
      if (ptr[c] != PTR_W'(REG)) all_full = 1'b0;
    end
  end

  assign fire       = fc_valid && fc_ready;
  assign last_beat  = (beat == BEAT_W'(BEATS - 1));
  assign last_class = (cls_idx == CLS_W'(CLASSES - 1));
  assign res_better = fc_result > best_score;
  assign win_idx    = res_better ? cls_idx : best_idx;
  assign rd_base    = FM_W'(beat) * FM_W'(FC_LANES);

  assign busy     = (state != S_IDLE);
  assign fc_valid = (state == S_STREAM);
  assign fc_last  = fc_valid && last_beat;
  assign fc_din   = fc_valid ? fmap[rd_base +: FC_LANES] : '0;
  assign fc_class = cls_idx;
  assign ovalid   = (state == S_DONE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start) state_nx = S_CONV;
      S_CONV:     if (all_full) state_nx = S_STREAM;
      S_STREAM:   if (fire && last_beat) state_nx = S_WAIT_RES;
      S_WAIT_RES: if (fc_result_valid) state_nx = last_class ? S_DONE : S_STREAM;
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Feature-map storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CONV_N; c++)
      if (wr_en[c]) fmap[wr_idx[c]] <= conv_result[c];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      conv_start <= '0;
      for (int c = 0; c < CONV_N; c++) ptr[c] <= '0;
      beat       <= '0;
      cls_idx    <= '0;
      best_score <= '0;
      best_idx   <= '0;
      classes    <= '0;
      overflow   <= 1'b0;
    end else begin
      conv_start <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            conv_start <= '1;
            for (int c = 0; c < CONV_N; c++) ptr[c] <= '0;
            overflow <= 1'b0;
          end
        end
        S_CONV: begin
          for (int c = 0; c < CONV_N; c++) begin
            if (wr_en[c]) ptr[c] <= ptr[c] + 1'b1;
            else if (conv_result_valid[c]) overflow <= 1'b1;
          end
          if (all_full) begin
            beat       <= '0;
            cls_idx    <= '0;
            best_score <= {1'b1, {(SCORE_W-1){1'b0}}};
            best_idx   <= '0;
          end
        end
        S_STREAM: begin
          if (fire) beat <= last_beat ? '0 : beat + 1'b1;
        end
        S_WAIT_RES: begin
          if (fc_result_valid) begin
            if (res_better) begin
              best_score <= fc_result;
              best_idx   <= cls_idx;
            end
            // The final winner is registered here so classes is ready alongside ovalid.
            if (!last_class) begin
              cls_idx <= cls_idx + 1'b1;
              beat    <= '0;
            end else begin
              classes <= {{(CLASSES-1){1'b0}}, 1'b1} << win_idx;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_seq_controller.sv
// Directed bench for bnn_seq_controller: default 3x12x10 instance plus a small 4x8x4 instance.
module tb_bnn_seq_controller;

  localparam int REG   = 676;
  localparam int BEATS = 169;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [2:0]  conv_start, conv_result, conv_result_valid;
  logic [11:0] fc_din;
  logic        fc_valid, fc_ready, fc_last;
  logic [3:0]  fc_class;
  logic [11:0] fc_result;
  logic        fc_result_valid;
  logic [9:0]  classes;
  logic        ovalid, busy, overflow;

  logic        s_start;
  logic [3:0]  s_conv_start, s_conv_result, s_conv_result_valid;
  logic [7:0]  s_fc_din;
  logic        s_fc_valid, s_fc_ready, s_fc_last;
  logic [1:0]  s_fc_class;
  logic [11:0] s_fc_result;
  logic        s_fc_result_valid;
  logic [3:0]  s_classes;
  logic        s_ovalid, s_busy, s_overflow;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  logic [9:0]  cls_q[$];
  bit fm  [0:2027];
  bit sfm [0:63];
  int best_s, best_i;
  int sc_a [10] = '{-5, 3, 7, 7, -2048, 0, 1, 2, 6, -1};
  int sc_b [4]  = '{1, 9, -3, 9};

  always #5 clk = ~clk;

  bnn_seq_controller u_dut (
    .clk(clk), .rstn(rstn), .start(start), .conv_start(conv_start),
    .conv_result(conv_result), .conv_result_valid(conv_result_valid),
    .fc_din(fc_din), .fc_valid(fc_valid), .fc_ready(fc_ready), .fc_last(fc_last),
    .fc_class(fc_class), .fc_result(fc_result), .fc_result_valid(fc_result_valid),
    .classes(classes), .ovalid(ovalid), .busy(busy), .overflow(overflow)
  );

  bnn_seq_controller #(.CONV_N(4), .FC_LANES(8), .FMAP_BITS(64), .CLASSES(4), .SCORE_W(12)) u_small (
    .clk(clk), .rstn(rstn), .start(s_start), .conv_start(s_conv_start),
    .conv_result(s_conv_result), .conv_result_valid(s_conv_result_valid),
    .fc_din(s_fc_din), .fc_valid(s_fc_valid), .fc_ready(s_fc_ready), .fc_last(s_fc_last),
    .fc_class(s_fc_class), .fc_result(s_fc_result), .fc_result_valid(s_fc_result_valid),
    .classes(s_classes), .ovalid(s_ovalid), .busy(s_busy), .overflow(s_overflow)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("conv_start_pulse", 32'(conv_start), 32'h7);
    check("busy_after_start", 32'(busy), 1);
  endtask

  task automatic load_conv(input logic [2:0] mask, input bit rnd);
    for (int i = 0; i < REG; i++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        bit v;
        v = rnd ? 1'($urandom_range(0, 1)) : (c == 0);
        if (mask[c]) fm[c*REG+i] = v;
        conv_result[c] = v;
      end
      conv_result_valid = mask;
    end
    @(negedge clk); conv_result_valid = 3'b000;
  endtask

  task automatic wait_fc_valid();
    int w;
    w = 0;
    while (!fc_valid && w < 10) begin
      @(negedge clk); w++;
    end
    check("fc_valid_latency", w, 1);
  endtask

  task automatic big_class(input int k, input int score, input int stall_at, input bit rnd);
    int hs, cyc, stall_n;
    logic [11:0] w, e, cap_din;
    logic        cap_last;
    logic [3:0]  cap_cls;
    logic [9:0]  one;
    hs = 0; cyc = 0; stall_n = 0; one = 10'd1;
    cap_din = '0; cap_last = 1'b0; cap_cls = '0;
    for (int b = 0; b < BEATS; b++) begin
      for (int l = 0; l < 12; l++) w[l] = fm[b*12+l];
      exp_q.push_back(w);
    end
    while (hs < BEATS && cyc < 3000) begin
      @(negedge clk); cyc++;
      fc_result_valid = 1'b0; start = 1'b0;
      if (hs == stall_at && stall_n < 5) begin
        fc_ready = 1'b0;
        if (stall_n == 0) begin
          cap_din = fc_din; cap_last = fc_last; cap_cls = fc_class;
          fc_result = 12'h7FF; fc_result_valid = 1'b1; start = 1'b1;
        end else begin
          check("stall_din", 32'(fc_din), 32'(cap_din));
          check("stall_last", 32'(fc_last), 32'(cap_last));
          check("stall_class", 32'(fc_class), 32'(cap_cls));
          if (stall_n == 1) check("start_ignored", 32'(conv_start), 0);
        end
        stall_n++;
      end else begin
        fc_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (fc_valid && fc_ready) begin
          e = exp_q.pop_front();
          check("fc_din", 32'(fc_din), 32'(e));
          check("fc_class", 32'(fc_class), k);
          check("fc_last", 32'(fc_last), 32'(hs == BEATS - 1));
          hs++;
        end
      end
    end
    check("handshakes", hs, BEATS);
    @(negedge clk); fc_ready = 1'b0;
    check("wait_res_no_valid", 32'(fc_valid), 0);
    fc_result = 12'(score); fc_result_valid = 1'b1;
    if (score > best_s) begin best_s = score; best_i = k; end
    if (k == 9) cls_q.push_back(one << best_i);
    @(negedge clk); fc_result_valid = 1'b0;
    if (k < 9) check("next_class_valid", 32'(fc_valid), 1);
    else begin
      check("ovalid_pulse", 32'(ovalid), 1);
      check("classes", 32'(classes), 32'(cls_q.pop_front()));
    end
  endtask

  task automatic small_class(input int k, input int score);
    int hs, cyc;
    logic [7:0] w;
    logic [11:0] e;
    logic [3:0] one;
    hs = 0; cyc = 0; one = 4'd1;
    for (int b = 0; b < 8; b++) begin
      for (int l = 0; l < 8; l++) w[l] = sfm[b*8+l];
      exp_q.push_back(12'(w));
    end
    while (hs < 8 && cyc < 100) begin
      @(negedge clk); cyc++;
      s_fc_ready = 1'b1;
      if (s_fc_valid) begin
        e = exp_q.pop_front();
        check("s_fc_din", 32'(s_fc_din), 32'(e));
        check("s_fc_class", 32'(s_fc_class), k);
        check("s_fc_last", 32'(s_fc_last), 32'(hs == 7));
        hs++;
      end
    end
    check("s_handshakes", hs, 8);
    @(negedge clk); s_fc_ready = 1'b0;
    check("s_wait_res_no_valid", 32'(s_fc_valid), 0);
    s_fc_result = 12'(score); s_fc_result_valid = 1'b1;
    if (score > best_s) begin best_s = score; best_i = k; end
    @(negedge clk); s_fc_result_valid = 1'b0;
    if (k == 3) begin
      check("s_ovalid", 32'(s_ovalid), 1);
      check("s_classes_model", 32'(s_classes), 32'(one << best_i));
      check("s_classes_directed", 32'(s_classes), 32'h2);
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; conv_result = '0; conv_result_valid = '0;
    fc_ready = 1'b0; fc_result = '0; fc_result_valid = 1'b0;
    s_start = 1'b0; s_conv_result = '0; s_conv_result_valid = '0;
    s_fc_ready = 1'b0; s_fc_result = '0; s_fc_result_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_fc_valid", 32'(fc_valid), 0);
    check("rst_fc_din", 32'(fc_din), 0);
    check("rst_fc_last", 32'(fc_last), 0);
    check("rst_fc_class", 32'(fc_class), 0);
    check("rst_classes", 32'(classes), 0);
    check("rst_ovalid", 32'(ovalid), 0);
    check("rst_conv_start", 32'(conv_start), 0);
    check("rst_overflow", 32'(overflow), 0);
    rstn = 1'b1;

    // Inference 1: channel 0 all ones, directed scores, stall and start poke in class 0
    start_pulse();
    @(negedge clk);
    check("conv_start_one_cycle", 32'(conv_start), 0);
    load_conv(3'b111, 1'b0);
    wait_fc_valid();
    check("first_beat", 32'(fc_din), 32'hFFF);
    best_s = -2048; best_i = 0;
    for (int k = 0; k < 10; k++) big_class(k, sc_a[k], (k == 0) ? 60 : -1, 1'b0);
    check("classes_directed", 32'(classes), 32'h004);
    @(negedge clk);
    check("ovalid_one_cycle", 32'(ovalid), 0);
    check("busy_idle", 32'(busy), 0);

    // Inference 2: random data, overflow on channel 1, random backpressure and scores
    start_pulse();
    load_conv(3'b110, 1'b1);
    @(negedge clk);
    conv_result[1] = ~fm[REG + REG - 1];
    conv_result_valid = 3'b010;
    @(negedge clk); conv_result_valid = 3'b000;
    check("overflow_set", 32'(overflow), 1);
    load_conv(3'b001, 1'b1);
    wait_fc_valid();
    best_s = -2048; best_i = 0;
    for (int k = 0; k < 10; k++) big_class(k, int'($urandom_range(0, 4095)) - 2048, -1, 1'b1);
    check("overflow_sticky", 32'(overflow), 1);

    // Inference 3: start clears overflow, then async reset mid-stream
    start_pulse();
    check("overflow_cleared", 32'(overflow), 0);
    load_conv(3'b111, 1'b1);
    wait_fc_valid();
    repeat (3) begin @(negedge clk); fc_ready = 1'b1; end
    @(negedge clk); fc_ready = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_fc_valid", 32'(fc_valid), 0);
    check("arst_fc_din", 32'(fc_din), 0);
    check("arst_classes", 32'(classes), 0);
    check("arst_ovalid", 32'(ovalid), 0);
    @(negedge clk); rstn = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("post_rst_idle", 32'(busy), 0);

    // Small instance: 4 channels x 16 bits, 8 beats x 8 lanes, 4 classes
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    check("s_conv_start", 32'(s_conv_start), 32'hF);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        bit v;
        v = 1'($urandom_range(0, 1));
        sfm[c*16+i] = v;
        s_conv_result[c] = v;
      end
      s_conv_result_valid = 4'hF;
    end
    @(negedge clk); s_conv_result_valid = 4'h0;
    best_s = -2048; best_i = 0;
    for (int k = 0; k < 4; k++) small_class(k, sc_b[k]);
    @(negedge clk);
    check("s_ovalid_one_cycle", 32'(s_ovalid), 0);
    check("s_overflow", 32'(s_overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
